// File: rtl/button_conditioner.sv
// Push-button front end: per channel 2-FF synchroniser, counter debouncer,
// registered press/release pulses and optional hold-to-repeat.
module button_conditioner #(
    parameter int               N_BTN           = 5,
    parameter int               DEBOUNCE_CYCLES = 1000000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = 5'b01111,
    parameter int               REPEAT_DELAY    = 50000000,
    parameter int               REPEAT_PERIOD   = 20000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    localparam int DW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(RPT_MAX);

    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HELD,
        S_WAIT,
        S_REPEAT
    } rpt_state_e;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [DW-1:0] db_cnt;
        logic          level_q;
        logic          accept;
        logic          rise;
        logic          fall;

        rpt_state_e    state_q;
        rpt_state_e    state_d;
        logic [RW-1:0] rpt_cnt_q;
        logic [RW-1:0] rpt_cnt_d;
        logic          press_d;
        logic          press_q;
        logic          release_q;

        // A level change is accepted on the DEBOUNCE_CYCLES-th consecutive disagreeing sample
        assign accept = (sync2[i] != level_q) && (db_cnt == DB_LAST);
        assign rise   = accept && !level_q;
        assign fall   = accept && level_q;

        always_ff @(posedge clk) begin
            if (!rst) begin
                db_cnt  <= '0;
                level_q <= 1'b0;
            end else if (sync2[i] != level_q) begin
                if (accept) begin
                    level_q <= ~level_q;
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end

        always_comb begin
            state_d   = state_q;
            rpt_cnt_d = rpt_cnt_q;
            press_d   = 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        press_d   = 1'b1;
                        rpt_cnt_d = '0;
                        state_d   = REPEAT_MASK[i] ? S_WAIT : S_HELD;
                    end
                end
                S_HELD: begin
                    if (fall) state_d = S_IDLE;
                end
                S_WAIT, S_REPEAT: begin
                    // Release wins over a repeat pulse falling on the same edge
                    if (fall) begin
                        state_d   = S_IDLE;
                        rpt_cnt_d = '0;
                    end else if (rpt_cnt_q == ((state_q == S_WAIT) ? DELAY_LAST : PERIOD_LAST)) begin
                        press_d   = 1'b1;
                        rpt_cnt_d = '0;
                        state_d   = S_REPEAT;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                state_q   <= S_IDLE;
                rpt_cnt_q <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                rpt_cnt_q <= rpt_cnt_d;
                press_q   <= press_d;
                release_q <= fall;
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed vector table, hand
// sequences for play/no-repeat and reset mid-hold, then randomized vs a model.
module tb_button_conditioner;

    localparam int         NB     = 5;
    localparam int         DEB    = 4;
    localparam int         DELAY  = 10;
    localparam int         PERIOD = 3;
    localparam logic [4:0] MASK   = 5'b01111;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;

    int checks = 0;
    int errors = 0;

    button_conditioner #(
        .N_BTN          (NB),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_MASK    (MASK),
        .REPEAT_DELAY   (DELAY),
        .REPEAT_PERIOD  (PERIOD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    // Reference model: level follows the synchronised input once the last DEB
    // synchronised samples all disagree with it; repeats are timed arithmetically
    // from the press edge.
    logic [NB-1:0] hist[$];
    logic [NB-1:0] m_level, m_press, m_rel;
    int            cyc;
    int            rise_t[NB];

    function automatic logic [NB-1:0] sample_ago(input int k);
        return (k < hist.size()) ? hist[k] : '0;
    endfunction

    task automatic model_edge(input logic r, input logic [NB-1:0] raw);
        logic [NB-1:0] np, nr;
        logic          all_diff;
        int            d;
        np = '0;
        nr = '0;
        if (!r) begin
            hist.delete();
            m_level = '0;
            cyc     = 0;
            for (int i = 0; i < NB; i++) rise_t[i] = 0;
        end else begin
            cyc++;
            hist.push_front(raw);
            for (int i = 0; i < NB; i++) begin
                all_diff = 1'b1;
                for (int k = 2; k <= DEB + 1; k++) begin
                    logic [NB-1:0] s;
                    s = sample_ago(k);
                    if (s[i] == m_level[i]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_level[i] = ~m_level[i];
                    if (m_level[i]) begin
                        np[i]     = 1'b1;
                        rise_t[i] = cyc;
                    end else begin
                        nr[i] = 1'b1;
                    end
                end else if (m_level[i] && MASK[i]) begin
                    d = cyc - rise_t[i];
                    if (d == DELAY || (d > DELAY && ((d - DELAY) % PERIOD) == 0)) np[i] = 1'b1;
                end
            end
            while (hist.size() > DEB + 2) void'(hist.pop_back());
        end
        m_press = np;
        m_rel   = nr;
    endtask

    task automatic step(input logic r, input logic [NB-1:0] raw);
        rst     = r;
        btn_raw = raw;
        @(posedge clk);
        model_edge(r, raw);
        #1;
    endtask

    task automatic check(input string name, input logic [NB-1:0] lv, input logic [NB-1:0] pr,
                         input logic [NB-1:0] rl);
        checks++;
        if ({btn_level, btn_press, btn_release} !== {lv, pr, rl}) begin
            errors++;
            $display("FAIL %s t=%0t level=%b/%b press=%b/%b release=%b/%b (got/want)",
                     name, $time, btn_level, lv, btn_press, pr, btn_release, rl);
        end
    endtask

    typedef struct packed {
        int            n;
        logic          r;
        logic [NB-1:0] raw;
        logic [NB-1:0] lvl;
        logic [NB-1:0] prs;
        logic [NB-1:0] rel;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input logic r, input logic [NB-1:0] raw,
                       input logic [NB-1:0] lvl, input logic [NB-1:0] prs, input logic [NB-1:0] rel);
        vec_t v;
        v.n = n; v.r = r; v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel;
        tbl.push_back(v);
    endtask

    initial begin
        logic [NB-1:0] raw;
        logic [NB-1:0] lv, pr;

        // Up: press, auto-repeat, release (counts are edges after reset)
        add(1, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        add(5, 1'b1, 5'b00100, 5'b00000, 5'b00000, 5'b00000);
        add(1, 1'b1, 5'b00100, 5'b00100, 5'b00100, 5'b00000);  // edge 6
        add(9, 1'b1, 5'b00100, 5'b00100, 5'b00000, 5'b00000);
        add(1, 1'b1, 5'b00100, 5'b00100, 5'b00100, 5'b00000);  // edge 16
        add(2, 1'b1, 5'b00100, 5'b00100, 5'b00000, 5'b00000);
        add(1, 1'b1, 5'b00100, 5'b00100, 5'b00100, 5'b00000);  // edge 19
        add(2, 1'b1, 5'b00100, 5'b00100, 5'b00000, 5'b00000);
        add(1, 1'b1, 5'b00100, 5'b00100, 5'b00100, 5'b00000);  // edge 22
        add(2, 1'b1, 5'b00100, 5'b00100, 5'b00000, 5'b00000);
        add(1, 1'b1, 5'b00100, 5'b00100, 5'b00100, 5'b00000);  // edge 25
        add(2, 1'b1, 5'b00100, 5'b00100, 5'b00000, 5'b00000);
        add(1, 1'b1, 5'b00100, 5'b00100, 5'b00100, 5'b00000);  // edge 28
        add(1, 1'b1, 5'b00100, 5'b00100, 5'b00000, 5'b00000);
        add(1, 1'b1, 5'b00000, 5'b00100, 5'b00000, 5'b00000);  // edge 30, raw released
        add(1, 1'b1, 5'b00000, 5'b00100, 5'b00100, 5'b00000);  // edge 31
        add(2, 1'b1, 5'b00000, 5'b00100, 5'b00000, 5'b00000);
        add(1, 1'b1, 5'b00000, 5'b00100, 5'b00100, 5'b00000);  // edge 34
        add(1, 1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00100);  // edge 35
        add(5, 1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        // Left: 3-cycle glitch rejected
        add(3, 1'b1, 5'b00001, 5'b00000, 5'b00000, 5'b00000);
        add(8, 1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        // Simultaneous press and release on three channels
        add(5, 1'b1, 5'b10011, 5'b00000, 5'b00000, 5'b00000);
        add(1, 1'b1, 5'b10011, 5'b10011, 5'b10011, 5'b00000);
        add(5, 1'b1, 5'b00000, 5'b10011, 5'b00000, 5'b00000);
        add(1, 1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b10011);
        add(3, 1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000);

        repeat (2) @(posedge clk);
        #1;
        foreach (tbl[v]) begin
            for (int c = 0; c < tbl[v].n; c++) begin
                step(tbl[v].r, tbl[v].raw);
                check($sformatf("vec%0d.%0d", v, c), tbl[v].lvl, tbl[v].prs, tbl[v].rel);
            end
        end

        // Play held 40 edges: a single press, no repeat, release 6 edges after raw drop
        step(1'b0, '0);
        for (int e = 1; e <= 52; e++) begin
            step(1'b1, (e <= 40) ? 5'b10000 : 5'b00000);
            check($sformatf("play.e%0d", e),
                  (e >= 6 && e <= 45) ? 5'b10000 : 5'b00000,
                  (e == 6) ? 5'b10000 : 5'b00000,
                  (e == 46) ? 5'b10000 : 5'b00000);
        end

        // Down held into REPEAT, then a one-edge reset while still held
        step(1'b0, '0);
        for (int e = 1; e <= 20; e++) step(1'b1, 5'b01000);
        check("hold.pre_rst", 5'b01000, 5'b00000, 5'b00000);
        step(1'b0, 5'b01000);
        check("hold.rst", 5'b00000, 5'b00000, 5'b00000);
        for (int e = 1; e <= 8; e++) begin
            step(1'b1, 5'b01000);
            check($sformatf("hold.after_rst.e%0d", e),
                  (e >= 6) ? 5'b01000 : 5'b00000,
                  (e == 6) ? 5'b01000 : 5'b00000,
                  5'b00000);
        end

        // Randomized: long holds, glitches and occasional resets against the model
        step(1'b0, '0);
        raw = '0;
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, 23) == 0) raw[i] = ~raw[i];
            step(($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1, raw);
            lv = m_level;
            pr = m_press;
            check($sformatf("rand.%0d", n), lv, pr, m_rel);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
